// File: rtl/kwta_pkg.sv
// kwta_pkg: shared types and width helpers for the lateral-inhibition k-WTA block.
// Holds the FSM state enum, the winner-id / time / count width functions and
// the all-ones NO_WINNER constant (sliced to the id width by its users).
package kwta_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } kwta_state_e;

  // All-ones pattern; users take the low ID_W bits to mean "no winner yet".
  localparam logic [31:0] NO_WINNER = '1;

  // Winner id carries one extra bit so the all-ones code never aliases a neuron.
  function automatic int id_w(input int num_neurons);
    return $clog2(num_neurons) + 1;
  endfunction

  function automatic int time_w(input int time_period);
    return (time_period > 1) ? $clog2(time_period) : 1;
  endfunction

  function automatic int cnt_w(input int k_winners);
    return (k_winners > 0) ? $clog2(k_winners + 1) : 1;
  endfunction

endpackage

// File: rtl/lateral_inhibition_kwta_if.sv
// lateral_inhibition_kwta_if: spike input / winner output bundle for the k-WTA layer.
// master: spike source and result consumer (drives start, spike_volley).
// slave : the k-WTA block (drives gated_volley, winner_*, won_mask, win_count, busy, done).
interface lateral_inhibition_kwta_if #(
  parameter int NUM_NEURONS = 16,
  parameter int K_WINNERS   = 1,
  parameter int TIME_PERIOD = 16
);
  import kwta_pkg::*;

  localparam int ID_W = id_w(NUM_NEURONS);
  localparam int T_W  = time_w(TIME_PERIOD);
  localparam int C_W  = cnt_w(K_WINNERS);

  logic                   start;
  logic [NUM_NEURONS-1:0] spike_volley;
  logic [NUM_NEURONS-1:0] gated_volley;
  logic                   winner_valid;
  logic [ID_W-1:0]        winner_id;
  logic [T_W-1:0]         winner_time;
  logic [NUM_NEURONS-1:0] won_mask;
  logic [C_W-1:0]         win_count;
  logic                   busy;
  logic                   done;

  modport master (
    output start, spike_volley,
    input  gated_volley, winner_valid, winner_id, winner_time,
           won_mask, win_count, busy, done
  );

  modport slave (
    input  start, spike_volley,
    output gated_volley, winner_valid, winner_id, winner_time,
           won_mask, win_count, busy, done
  );

endinterface

// File: rtl/lateral_inhibition_kwta_priority_select.sv
// priority_select: combinational one-of-N picker over a request vector.
// Ports: req (WIDTH) in; found, idx (IDX_W), onehot (WIDTH) out.
// TIE_HIGH=1 picks the highest set bit, TIE_HIGH=0 the lowest. No state, zero latency.
module priority_select #(
  parameter int WIDTH    = 16,
  parameter int TIE_HIGH = 1,
  parameter int IDX_W    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] onehot
);

  // Ascending scan: with TIE_HIGH every later hit overrides, so the last
  // (highest) set bit wins; otherwise only the first hit is taken.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i] && ((TIE_HIGH != 0) || !found)) begin
        found     = 1'b1;
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lateral_inhibition_kwta.sv
// lateral_inhibition_kwta: k-winner-take-all lateral inhibition over one gamma cycle.
// Ports: clk, rst_l (async active-low), bus (slave modport: start/spike_volley in,
// gated_volley/winner_valid/winner_id/winner_time/won_mask/win_count/busy/done out).
// Winners and gated spikes are registered: visible the cycle after the spike.
module lateral_inhibition_kwta
  import kwta_pkg::*;
#(
  parameter int NUM_NEURONS    = 16,
  parameter int K_WINNERS      = 1,
  parameter int TIME_PERIOD    = 16,
  parameter int TESTING_PERIOD = 12,
  parameter int TIE_HIGH       = 1
) (
  input  logic                        clk,
  input  logic                        rst_l,
  lateral_inhibition_kwta_if.slave    bus
);

  localparam int ID_W = id_w(NUM_NEURONS);
  localparam int T_W  = time_w(TIME_PERIOD);
  localparam int C_W  = cnt_w(K_WINNERS);

  kwta_state_e            state_q, state_d;
  logic [T_W-1:0]         time_q;
  logic [NUM_NEURONS-1:0] won_mask_q;
  logic [C_W-1:0]         win_count_q;
  logic [ID_W-1:0]        winner_id_q;
  logic [T_W-1:0]         winner_time_q;
  logic                   winner_valid_q;
  logic [NUM_NEURONS-1:0] gated_q;

  logic                   start_run;
  logic                   in_run;
  logic                   latch_en;
  logic [NUM_NEURONS-1:0] candidates;
  logic                   sel_found;
  logic [ID_W-1:0]        sel_idx;
  logic [NUM_NEURONS-1:0] sel_onehot;
  logic [NUM_NEURONS-1:0] pass_mask;

  // Neurons that already won this gamma cycle cannot win again.
  assign candidates = bus.spike_volley & ~won_mask_q;

  priority_select #(
    .WIDTH    (NUM_NEURONS),
    .TIE_HIGH (TIE_HIGH),
    .IDX_W    (ID_W)
  ) u_select (
    .req    (candidates),
    .found  (sel_found),
    .idx    (sel_idx),
    .onehot (sel_onehot)
  );

  assign in_run   = (state_q == ST_RUN);
  assign latch_en = in_run && sel_found
                 && (32'(time_q) < TESTING_PERIOD)
                 && (32'(win_count_q) < K_WINNERS);

  // Spikes pass if the neuron already won or wins right now; everything else
  // is inhibited, including losers of a same-cycle tie.
  assign pass_mask = won_mask_q | (latch_en ? sel_onehot : '0);

  // FSM next state. start outside IDLE is dropped, never remembered.
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          start_run = 1'b1;
        end
      end
      ST_RUN: begin
        if (32'(time_q) == TIME_PERIOD - 1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: results hold through DONE/IDLE and are only cleared by the next start.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      time_q         <= '0;
      won_mask_q     <= '0;
      win_count_q    <= '0;
      winner_id_q    <= NO_WINNER[ID_W-1:0];
      winner_time_q  <= '0;
      winner_valid_q <= 1'b0;
      gated_q        <= '0;
    end else begin
      winner_valid_q <= 1'b0;
      gated_q        <= '0;
      if (start_run) begin
        time_q        <= '0;
        won_mask_q    <= '0;
        win_count_q   <= '0;
        winner_id_q   <= NO_WINNER[ID_W-1:0];
        winner_time_q <= '0;
      end else if (in_run) begin
        time_q  <= time_q + 1'b1;
        gated_q <= bus.spike_volley & pass_mask;
        if (latch_en) begin
          winner_valid_q <= 1'b1;
          winner_id_q    <= sel_idx;
          winner_time_q  <= time_q;
          won_mask_q     <= won_mask_q | sel_onehot;
          win_count_q    <= win_count_q + 1'b1;
        end
      end
    end
  end

  assign bus.gated_volley = gated_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.winner_id    = winner_id_q;
  assign bus.winner_time  = winner_time_q;
  assign bus.won_mask     = won_mask_q;
  assign bus.win_count    = win_count_q;
  assign bus.busy         = in_run;
  assign bus.done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_lateral_inhibition_kwta.sv
// Directed bench: dut_a is K=1/TIE_HIGH=1, dut_b is K=2/TIE_HIGH=0, both N=16, period 16.
module tb_lateral_inhibition_kwta;

  logic clk;
  logic rst_l;
  int   n_vec;
  int   n_err;

  lateral_inhibition_kwta_if #(.NUM_NEURONS(16), .K_WINNERS(1), .TIME_PERIOD(16)) if_a ();
  lateral_inhibition_kwta_if #(.NUM_NEURONS(16), .K_WINNERS(2), .TIME_PERIOD(16)) if_b ();

  lateral_inhibition_kwta #(
    .NUM_NEURONS(16), .K_WINNERS(1), .TIME_PERIOD(16), .TESTING_PERIOD(12), .TIE_HIGH(1)
  ) dut_a (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (if_a)
  );

  lateral_inhibition_kwta #(
    .NUM_NEURONS(16), .K_WINNERS(2), .TIME_PERIOD(16), .TESTING_PERIOD(12), .TIE_HIGH(0)
  ) dut_b (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_a_idle_reset(input string tag);
    chk({tag, "_id"},    32'(if_a.winner_id),    32'h1f);
    chk({tag, "_time"},  32'(if_a.winner_time),  32'h0);
    chk({tag, "_mask"},  32'(if_a.won_mask),     32'h0);
    chk({tag, "_cnt"},   32'(if_a.win_count),    32'h0);
    chk({tag, "_busy"},  32'(if_a.busy),         32'h0);
    chk({tag, "_done"},  32'(if_a.done),         32'h0);
    chk({tag, "_valid"}, 32'(if_a.winner_valid), 32'h0);
    chk({tag, "_gated"}, 32'(if_a.gated_volley), 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_l = 1'b0;
    if_a.start = 1'b0; if_a.spike_volley = '0;
    if_b.start = 1'b0; if_b.spike_volley = '0;

    // Reset state
    #12;
    chk_a_idle_reset("rst_a");
    chk("rst_b_id",  32'(if_b.winner_id), 32'h1f);
    chk("rst_b_cnt", 32'(if_b.win_count), 32'h0);
    rst_l = 1'b1;
    tick();

    // K=1, tie high: spikes 2,7 at t=3 -> 7 wins; later 2 inhibited, 7 passes
    if_a.start = 1'b1; tick(); if_a.start = 1'b0;
    chk("s1_busy", 32'(if_a.busy), 32'h1);
    tick_n(3);
    if_a.spike_volley = 16'h0084; tick();
    chk("s1_valid", 32'(if_a.winner_valid), 32'h1);
    chk("s1_id",    32'(if_a.winner_id),    32'h7);
    chk("s1_time",  32'(if_a.winner_time),  32'h3);
    chk("s1_mask",  32'(if_a.won_mask),     32'h0080);
    chk("s1_cnt",   32'(if_a.win_count),    32'h1);
    chk("s1_gated", 32'(if_a.gated_volley), 32'h0080);
    if_a.spike_volley = 16'h0000; tick();
    chk("s1_valid_drop", 32'(if_a.winner_valid), 32'h0);
    if_a.spike_volley = 16'h0004; tick();
    chk("s1_inhib", 32'(if_a.gated_volley), 32'h0000);
    chk("s1_cnt2",  32'(if_a.win_count),    32'h1);
    if_a.spike_volley = 16'h0080; tick();
    chk("s1_winner_pass", 32'(if_a.gated_volley), 32'h0080);
    chk("s1_no_relatch",  32'(if_a.winner_valid), 32'h0);
    if_a.spike_volley = 16'h0000;
    tick_n(8);
    chk("s1_pre_done", 32'(if_a.done), 32'h0);
    tick();
    chk("s1_done",      32'(if_a.done), 32'h1);
    chk("s1_done_busy", 32'(if_a.busy), 32'h0);
    tick();
    chk("s1_done_pulse", 32'(if_a.done),      32'h0);
    chk("s1_hold_id",    32'(if_a.winner_id), 32'h7);
    chk("s1_hold_mask",  32'(if_a.won_mask),  32'h0080);

    // K=2, tie low: 4,9 at t=1 -> 4; 9 at t=2 -> 9; 11 at t=4 inhibited
    if_b.start = 1'b1; tick(); if_b.start = 1'b0;
    tick();
    if_b.spike_volley = 16'h0210; tick();
    chk("s2_id1",    32'(if_b.winner_id),    32'h4);
    chk("s2_time1",  32'(if_b.winner_time),  32'h1);
    chk("s2_gated1", 32'(if_b.gated_volley), 32'h0010);
    if_b.spike_volley = 16'h0200; tick();
    chk("s2_valid2", 32'(if_b.winner_valid), 32'h1);
    chk("s2_id2",    32'(if_b.winner_id),    32'h9);
    chk("s2_time2",  32'(if_b.winner_time),  32'h2);
    chk("s2_cnt",    32'(if_b.win_count),    32'h2);
    chk("s2_mask",   32'(if_b.won_mask),     32'h0210);
    if_b.spike_volley = 16'h0000; tick();
    if_b.spike_volley = 16'h0810; tick();
    chk("s2_inhib11", 32'(if_b.gated_volley), 32'h0010);
    chk("s2_full",    32'(if_b.winner_valid), 32'h0);
    chk("s2_cnt_hold",32'(if_b.win_count),    32'h2);
    if_b.spike_volley = 16'h0000;
    tick_n(10);
    chk("s2_pre_done", 32'(if_b.done), 32'h0);
    tick();
    chk("s2_done", 32'(if_b.done), 32'h1);
    tick();

    // Spike at t=12 is past the testing window: no winner, 16 RUN cycles
    if_a.start = 1'b1; tick(); if_a.start = 1'b0;
    chk("s3_clear_mask", 32'(if_a.won_mask), 32'h0);
    tick_n(12);
    if_a.spike_volley = 16'h0020; tick();
    chk("s3_valid", 32'(if_a.winner_valid), 32'h0);
    chk("s3_gated", 32'(if_a.gated_volley), 32'h0);
    if_a.spike_volley = 16'h0000;
    tick_n(2);
    chk("s3_busy15", 32'(if_a.busy), 32'h1);
    tick();
    chk("s3_done", 32'(if_a.done),      32'h1);
    chk("s3_id",   32'(if_a.winner_id), 32'h1f);
    chk("s3_cnt",  32'(if_a.win_count), 32'h0);
    tick();

    // start at t=6 during RUN is ignored, done stays on schedule and is not re-run
    if_a.start = 1'b1; tick(); if_a.start = 1'b0;
    tick_n(6);
    if_a.start = 1'b1; tick(); if_a.start = 1'b0;
    tick_n(8);
    chk("s4_pre_done", 32'(if_a.done), 32'h0);
    tick();
    chk("s4_done", 32'(if_a.done), 32'h1);
    tick();
    tick();
    chk("s4_not_queued", 32'(if_a.busy), 32'h0);

    // Async reset at t=8 after a winner at t=2
    if_a.start = 1'b1; tick(); if_a.start = 1'b0;
    tick_n(2);
    if_a.spike_volley = 16'h0008; tick();
    chk("s5_id", 32'(if_a.winner_id), 32'h3);
    if_a.spike_volley = 16'h0000;
    tick_n(5);
    rst_l = 1'b0;
    #1;
    chk_a_idle_reset("s5_arst");
    #3;
    rst_l = 1'b1;
    if_a.start = 1'b1; tick(); if_a.start = 1'b0;
    chk("s5_restart_busy", 32'(if_a.busy), 32'h1);
    if_a.spike_volley = 16'h0008; tick();
    chk("s5_clean_id",   32'(if_a.winner_id),   32'h3);
    chk("s5_clean_time", 32'(if_a.winner_time), 32'h0);
    if_a.spike_volley = 16'h0000;
    tick_n(14);
    tick();
    chk("s5_done", 32'(if_a.done), 32'h1);

    // Back-to-back: start right after done, prior winner 3 wins again
    tick();
    if_a.start = 1'b1; tick(); if_a.start = 1'b0;
    chk("s6_mask_clr", 32'(if_a.won_mask),  32'h0);
    chk("s6_id_clr",   32'(if_a.winner_id), 32'h1f);
    if_a.spike_volley = 16'h0008; tick();
    chk("s6_rewin_valid", 32'(if_a.winner_valid), 32'h1);
    chk("s6_rewin_mask",  32'(if_a.won_mask),     32'h0008);
    if_a.spike_volley = 16'h0000;
    tick_n(15);
    chk("s6_done", 32'(if_a.done), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lateral_inhibition_kwta.md
LATERAL_INHIBITION_KWTA -- requirements
Module: lateral_inhibition_kwta

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 16: neurons in the layer.
REQ-002 The block SHALL have parameter K_WINNERS, default 1: maximum winners per gamma cycle (1..NUM_NEURONS).
REQ-003 The block SHALL have parameter TIME_PERIOD, default 16: cycles per gamma cycle.
REQ-004 The block SHALL have parameter TESTING_PERIOD, default 12: winners are latched only while time < TESTING_PERIOD (<= TIME_PERIOD).
REQ-005 The block SHALL have parameter TIE_HIGH, default 1: 1 means the highest index wins a same-cycle tie; 0 means the lowest index wins.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst_l, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port start, input, 1 bit: single-cycle request to begin a gamma cycle.
REQ-009 The block SHALL have port spike_volley, input, NUM_NEURONS bits: raw neuron spikes for the current cycle.
REQ-010 The block SHALL have port gated_volley, output, NUM_NEURONS bits: registered spikes that survive inhibition.
REQ-011 The block SHALL have port winner_valid, output, 1 bit: pulses for one cycle when a winner is latched.
REQ-012 The block SHALL have port winner_id, output, ID_W = clog2(NUM_NEURONS)+1 bits: index of the latest winner; all-ones means none.
REQ-013 The block SHALL have port winner_time, output, clog2(TIME_PERIOD) bits: time of the latest winner.
REQ-014 The block SHALL have port won_mask, output, NUM_NEURONS bits: one-hot-per-winner accumulated mask.
REQ-015 The block SHALL have port win_count, output, clog2(K_WINNERS+1) bits: number of winners latched so far.
REQ-016 The block SHALL have port busy, output, 1 bit: asserted in state RUN.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a gamma cycle.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DONE, with transitions IDLE->RUN on start, RUN->DONE when time == TIME_PERIOD-1, and DONE->IDLE unconditionally.
REQ-019 On the IDLE->RUN transition, the block SHALL clear time to 0, won_mask to 0 and win_count to 0, and set winner_id to all-ones and winner_time to 0.
REQ-020 In RUN, time SHALL increment by 1 per cycle, and the first RUN cycle SHALL be time 0.
REQ-021 The candidate set each RUN cycle SHALL be spike_volley & ~won_mask.
REQ-022 A winner SHALL be latched in a RUN cycle only if the candidate set is non-zero, time < TESTING_PERIOD and win_count < K_WINNERS.
REQ-023 At most one winner SHALL be latched per cycle, selected by TIE_HIGH; the other candidates spiking in that cycle lose and are not deferred.
REQ-024 On a latch, the block SHALL register: winner_valid=1; winner_id=index; winner_time=time; won_mask bit set; win_count+1. All of these SHALL be visible the cycle after the spike.
REQ-025 gated_volley SHALL be registered, 1-cycle latency, equal to spike_volley & (won_mask | new-winner one-hot) during RUN, and 0 otherwise.
REQ-026 Once win_count == K_WINNERS, all further non-winner spikes SHALL be inhibited, while winners' later spikes still pass through gated_volley.
REQ-027 Spikes while time >= TESTING_PERIOD SHALL latch no winner.
REQ-028 start in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-029 done SHALL assert for exactly the DONE cycle, and winner_id, winner_time, won_mask and win_count SHALL hold their values through IDLE until the next start.
REQ-030 No-spike gamma cycle: the block SHALL finish with winner_id all-ones and win_count 0.

Reset
REQ-031 Asserting rst_l low at any time, including mid-RUN, SHALL asynchronously force IDLE, time=0, gated_volley=0, winner_valid=0, done=0, busy=0, won_mask=0, win_count=0, winner_id=all-ones and winner_time=0.
REQ-032 Deassertion of rst_l SHALL be synchronous to clk, and the first start accepted SHALL be on the first clk edge after deassertion.

Structure
REQ-033 A shared package kwta_pkg SHALL hold the FSM state enum, the ID_W and time-width functions, and the NO_WINNER all-ones constant.
REQ-034 Sub-module priority_select SHALL be parameterised by width and TIE_HIGH, and SHALL be combinational, outputting a found flag, an index and a one-hot vector.
REQ-035 All widths SHALL derive from the parameters, with no hard-coded neuron counts.

Verification
REQ-036 Scenario K=1, TIE_HIGH=1, N=16: start; at t=3, spikes at 2, 7 -> winner_id=7, winner_time=3, won_mask=0x0080; t=5 spike at 2 -> gated_volley=0.
REQ-037 Scenario K=2, TIE_HIGH=0: spikes at 4, 9 at t=1, then 9 at t=2 -> winners 4@1, 9@2, win_count=2; spike at 11 at t=4 -> inhibited.
REQ-038 Scenario: spike at 5 at t=12 with TESTING_PERIOD=12 -> no winner; done after 16 RUN cycles; winner_id=5'b11111.
REQ-039 Scenario: start pulsed at t=6 during RUN -> ignored; done occurs exactly at the original cycle.
REQ-040 Scenario: rst_l low at t=8 after one winner -> all outputs take reset values immediately; the next start gives a clean cycle.
REQ-041 Scenario: back-to-back starts in the cycle after done -> won_mask is cleared and a repeat spike by a prior winner can win again.
